// File: rtl/dot_capture.sv
// Receive side of the 8x8 dot-matrix scan: rebuilds the 64-bit frame bitmap from {row, col} samples.
// Optional: define DOT_CAPTURE_ERRCNT_EN to add the saturating 8-bit err_cnt output.
module dot_capture #(
  parameter int unsigned FRAME_SAMPLES = 64,
  parameter int unsigned TIMEOUT       = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sync,
  input  logic        vld,
  input  logic [15:0] d,
  input  logic        err_clr,
  output logic [63:0] q,
  output logic        q_vld,
  output logic        busy,
`ifdef DOT_CAPTURE_ERRCNT_EN
  output logic [7:0]  err_cnt,
`endif
  output logic        err
);

  localparam int unsigned TmoW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TmoW-1:0] TmoLast = TmoW'(TIMEOUT - 2);
  localparam logic [7:0] LastCnt = 8'(FRAME_SAMPLES - 1);

  typedef enum logic [0:0] {StIdle, StCapt} state_e;

  state_e          state_q, state_d;
  logic [63:0]     frame_q, frame_d;
  logic [7:0]      cnt_q, cnt_d;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic [63:0]     q_q, q_d;
  logic            q_vld_q, q_vld_d;
  logic            err_q, err_d;
  logic            err_ev;

  logic [7:0]  row, col;
  logic        blank, malformed;
  logic [63:0] hit, wr_mask;
  logic [63:0] base_frame;
  logic [7:0]  base_cnt;

  assign row = d[15:8];
  assign col = d[7:0];

  // Outer product of row and col: exactly one bit set when both are one-hot.
  always_comb begin
    hit = '0;
    for (int y = 0; y < 8; y++) begin
      for (int x = 0; x < 8; x++) begin
        hit[y*8+x] = row[y] & col[x];
      end
    end
  end

  assign blank     = (row == 8'h00) && (col == 8'h00);
  assign malformed = !blank && !($onehot(row) && $onehot(col));
  assign wr_mask   = malformed ? '0 : hit;

  always_comb begin
    state_d    = state_q;
    frame_d    = frame_q;
    cnt_d      = cnt_q;
    tmo_d      = tmo_q;
    q_d        = q_q;
    q_vld_d    = 1'b0;
    err_ev     = 1'b0;
    base_frame = sync ? '0 : frame_q;
    base_cnt   = sync ? 8'd0 : cnt_q;

    if (sync) begin
      // A sync while capturing discards the partial frame as a short frame.
      err_ev  = (state_q == StCapt);
      state_d = StCapt;
      frame_d = '0;
      cnt_d   = 8'd0;
      tmo_d   = '0;
    end

    if (sync || (state_q == StCapt)) begin
      if (vld) begin
        if (malformed) err_ev = 1'b1;
        tmo_d = '0;
        if (base_cnt == LastCnt) begin
          q_d     = base_frame | wr_mask;
          q_vld_d = 1'b1;
          state_d = StIdle;
          frame_d = '0;
          cnt_d   = 8'd0;
        end else begin
          frame_d = base_frame | wr_mask;
          cnt_d   = base_cnt + 8'd1;
        end
      end else if (!sync) begin
        if (tmo_q == TmoLast) begin
          err_ev  = 1'b1;
          state_d = StIdle;
          frame_d = '0;
          cnt_d   = 8'd0;
          tmo_d   = '0;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
      end
    end

    err_d = err_ev ? 1'b1 : (err_clr ? 1'b0 : err_q);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      frame_q <= '0;
      cnt_q   <= 8'd0;
      tmo_q   <= '0;
      q_q     <= '0;
      q_vld_q <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      frame_q <= frame_d;
      cnt_q   <= cnt_d;
      tmo_q   <= tmo_d;
      q_q     <= q_d;
      q_vld_q <= q_vld_d;
      err_q   <= err_d;
    end
  end

`ifdef DOT_CAPTURE_ERRCNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Coincident events count once; an event beats a same-cycle clear.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (err_ev) begin
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end else if (err_clr) begin
      err_cnt_d = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) err_cnt_q <= 8'd0;
    else     err_cnt_q <= err_cnt_d;
  end

  assign err_cnt = err_cnt_q;
`endif

  assign q     = q_q;
  assign q_vld = q_vld_q;
  assign busy  = (state_q == StCapt);
  assign err   = err_q;

endmodule

// File: tb/tb_dot_capture.sv
// Self-checking bench for dot_capture: vector table for short control sequences,
// hand-written frame sequences for capture, short frame, timeout, collisions and reset.
module tb_dot_capture;

  localparam int unsigned FS  = 64;
  localparam int unsigned TMO = 16;

  logic        clk = 1'b0;
  logic        rst, sync, vld, err_clr;
  logic [15:0] d;
  logic [63:0] q;
  logic        q_vld, busy, err;
`ifdef DOT_CAPTURE_ERRCNT_EN
  logic [7:0]  err_cnt;
`endif

  int checks  = 0;
  int errors  = 0;
  int qv_seen = 0;

  always #5 clk = ~clk;

  dot_capture #(
    .FRAME_SAMPLES(FS),
    .TIMEOUT      (TMO)
  ) dut (
    .clk    (clk),
    .rst    (rst),
    .sync   (sync),
    .vld    (vld),
    .d      (d),
    .err_clr(err_clr),
    .q      (q),
    .q_vld  (q_vld),
    .busy   (busy),
`ifdef DOT_CAPTURE_ERRCNT_EN
    .err_cnt(err_cnt),
`endif
    .err    (err)
  );

  typedef struct {
    logic        r;
    logic        s;
    logic        v;
    logic [15:0] dd;
    logic        c;
    logic        e_qvld;
    logic        e_busy;
    logic        e_err;
  } vec_t;

  vec_t tv[10];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // Inputs change at the falling edge; outputs are read at the next falling edge.
  task automatic drive(input logic s, input logic v, input logic [15:0] dd, input logic c,
                       input logic r);
    rst = r; sync = s; vld = v; d = dd; err_clr = c;
    @(posedge clk);
    @(negedge clk);
    if (q_vld) qv_seen++;
    rst = 1'b0; sync = 1'b0; vld = 1'b0; d = 16'h0; err_clr = 1'b0;
  endtask

  function automatic logic [15:0] word(input int i);
    logic [7:0] r, c;
    r = 8'h01 << (i / 8);
    c = 8'h01 << (i % 8);
    return {r, c};
  endfunction

  task automatic samples(input logic [63:0] pat, input int first, input int last, input int bad);
    for (int i = first; i <= last; i++) begin
      drive(1'b0, 1'b1, (i == bad) ? 16'h0303 : (pat[i] ? word(i) : 16'h0000), 1'b0, 1'b0);
    end
  endtask

  logic [63:0] cb;
  localparam logic [63:0] CbExp = 64'hAA55AA55AA55AA55;
  localparam logic [63:0] PatP  = 64'h0123456789ABCDEF;

  initial begin
    rst = 1'b1; sync = 1'b0; vld = 1'b0; d = 16'h0; err_clr = 1'b0;
    cb = '0;
    for (int i = 0; i < 64; i++) cb[i] = (((i / 8) + (i % 8)) % 2) == 0;

    //           r     s     v     d         clr   qvld  busy  err
    tv[0] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[1] = '{1'b0, 1'b0, 1'b1, 16'h0303, 1'b0, 1'b0, 1'b0, 1'b0};
    tv[2] = '{1'b0, 1'b1, 1'b1, 16'h0101, 1'b0, 1'b0, 1'b1, 1'b0};
    tv[3] = '{1'b0, 1'b0, 1'b1, 16'h0303, 1'b1, 1'b0, 1'b1, 1'b1};
    tv[4] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1};
    tv[5] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
    tv[6] = '{1'b0, 1'b0, 1'b1, 16'h0300, 1'b0, 1'b0, 1'b1, 1'b1};
    tv[7] = '{1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0};
    tv[8] = '{1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b1};
    tv[9] = '{1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0};

    @(negedge clk);
    for (int k = 0; k < 10; k++) begin
      drive(tv[k].s, tv[k].v, tv[k].dd, tv[k].c, tv[k].r);
      chk($sformatf("vec%0d q", k), q, 64'h0);
      chk($sformatf("vec%0d q_vld", k), {63'h0, q_vld}, {63'h0, tv[k].e_qvld});
      chk($sformatf("vec%0d busy", k), {63'h0, busy}, {63'h0, tv[k].e_busy});
      chk($sformatf("vec%0d err", k), {63'h0, err}, {63'h0, tv[k].e_err});
    end
`ifdef DOT_CAPTURE_ERRCNT_EN
    chk("reset err_cnt", {56'h0, err_cnt}, 64'h0);
`endif

    // Clean checkerboard frame.
    drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    chk("clean busy", {63'h0, busy}, 64'h1);
    qv_seen = 0;
    samples(cb, 0, 62, -1);
    chk("clean no early q_vld", qv_seen, 0);
    samples(cb, 63, 63, -1);
    chk("clean q_vld", {63'h0, q_vld}, 64'h1);
    chk("clean q", q, CbExp);
    chk("clean err", {63'h0, err}, 64'h0);
    chk("clean busy end", {63'h0, busy}, 64'h0);
    drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
    chk("clean q_vld one cycle", {63'h0, q_vld}, 64'h0);
    chk("clean q hold", q, CbExp);

    // Malformed sample 5 in an all-lit frame.
    drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    samples({64{1'b1}}, 0, 5, 5);
    chk("malformed err", {63'h0, err}, 64'h1);
    qv_seen = 0;
    samples({64{1'b1}}, 6, 63, -1);
    chk("malformed q_vld count", qv_seen, 1);
    chk("malformed q", q, 64'hFFFFFFFFFFFFFFDF);
`ifdef DOT_CAPTURE_ERRCNT_EN
    chk("malformed err_cnt", {56'h0, err_cnt}, 64'h1);
`endif

    // Short frame: 10 samples, then a fresh sync and 64 blanks.
    drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    chk("short err cleared", {63'h0, err}, 64'h0);
    drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) drive(1'b0, 1'b1, 16'h0101, 1'b0, 1'b0);
    drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    chk("short err", {63'h0, err}, 64'h1);
    chk("short busy", {63'h0, busy}, 64'h1);
    qv_seen = 0;
    samples(64'h0, 0, 63, -1);
    chk("short q_vld count", qv_seen, 1);
    chk("short q", q, 64'h0);
`ifdef DOT_CAPTURE_ERRCNT_EN
    chk("short err_cnt", {56'h0, err_cnt}, 64'h1);
`endif

    // Timeout after 3 samples with a published frame in q.
    drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    samples(cb, 0, 63, -1);
    drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    samples(cb, 0, 2, -1);
    qv_seen = 0;
    for (int k = 1; k <= 15; k++) begin
      drive(1'b0, 1'b0, 16'h0, 1'b0, 1'b0);
      if (k == 14) chk("timeout busy at 14", {63'h0, busy}, 64'h1);
    end
    chk("timeout busy at 15", {63'h0, busy}, 64'h0);
    chk("timeout err", {63'h0, err}, 64'h1);
    chk("timeout no q_vld", qv_seen, 0);
    chk("timeout q held", q, CbExp);
`ifdef DOT_CAPTURE_ERRCNT_EN
    chk("timeout err_cnt", {56'h0, err_cnt}, 64'h1);
`endif

    // Collisions: clear vs malformed, then sync on the final sample.
    drive(1'b0, 1'b0, 16'h0, 1'b1, 1'b0);
    drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    drive(1'b0, 1'b1, 16'h0303, 1'b1, 1'b0);
    chk("collide set beats clear", {63'h0, err}, 64'h1);
`ifdef DOT_CAPTURE_ERRCNT_EN
    chk("collide err_cnt", {56'h0, err_cnt}, 64'h1);
`endif
    samples(64'h0, 1, 62, -1);
    qv_seen = 0;
    drive(1'b1, 1'b1, 16'h8080, 1'b0, 1'b0);
    chk("sync final no q_vld", {63'h0, q_vld}, 64'h0);
    chk("sync final busy", {63'h0, busy}, 64'h1);
    chk("sync final q held", q, CbExp);
    samples(64'h0, 1, 62, -1);
    chk("restart no early q_vld", qv_seen, 0);
    samples(64'h0, 63, 63, -1);
    chk("restart q_vld count", qv_seen, 1);
    chk("restart q", q, 64'h8000000000000000);

    // Reset in the middle of a frame that already flagged an error.
    drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    samples(cb, 0, 29, 10);
    chk("midrst err before", {63'h0, err}, 64'h1);
    drive(1'b0, 1'b1, word(30), 1'b0, 1'b1);
    chk("midrst q", q, 64'h0);
    chk("midrst busy", {63'h0, busy}, 64'h0);
    chk("midrst err", {63'h0, err}, 64'h0);
`ifdef DOT_CAPTURE_ERRCNT_EN
    chk("midrst err_cnt", {56'h0, err_cnt}, 64'h0);
`endif
    drive(1'b1, 1'b0, 16'h0, 1'b0, 1'b0);
    qv_seen = 0;
    samples(PatP, 0, 63, -1);
    chk("fresh q_vld count", qv_seen, 1);
    chk("fresh q", q, PatP);
    chk("fresh err", {63'h0, err}, 64'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dot_capture.md
Name: dot_capture

Overview:
- Receive end of the 8x8 dot-matrix scan interface. Samples the 16-bit {row, col} drive word produced by the matrix scanner and rebuilds the 64-bit frame bitmap that generated it.
- Sits on the monitor/loopback path. Lets the CPU or a bench read back what the display was actually driven with.
- Frame bit mapping: bit index = y*8 + x, where row bit y and col bit x are asserted.

Parameters:
- FRAME_SAMPLES, 64, valid samples per frame; range 1..255.
- TIMEOUT, 1024, max clk cycles between valid samples inside a frame before the frame is aborted; must be >= 2.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- sync  input  1  frame-start strobe, one cycle.
- vld  input  1  the d input holds a scan sample this cycle.
- d  input  16  scan word {row[7:0], col[7:0]}; one-hot active-high row and col.
- err_clr  input  1  clears err.
- q  output  64  last completed frame bitmap.
- q_vld  output  1  one-cycle pulse when q is updated.
- busy  output  1  high while in CAPT.
- err  output  1  sticky error flag.

Behaviour:
- Reset (rst=1 at a clk edge):
  - q=0, q_vld=0, busy=0, err=0.
  - State IDLE; working buffer, sample count and timeout count all 0.
- States: IDLE, CAPT.
- IDLE:
  - vld samples are ignored.
  - sync=1 → CAPT; buffer cleared, cnt=0, tmo=0.
  - If vld=1 in the same cycle as sync, that sample is the first sample of the new frame.
- CAPT, per vld=1 sample:
  - row and col both one-hot: set buf[y*8+x].
  - row=0 and col=0: blank sample, no write.
  - Any other pattern (multi-hot, or exactly one of row/col zero): malformed. err set, no write.
  - Every sample, including blank and malformed, increments cnt and clears tmo.
- Frame complete: the vld sample taken while cnt==FRAME_SAMPLES-1.
  - At that edge, q <= buf OR the final sample's bit (same-cycle merge).
  - q_vld=1 for exactly the next cycle; state → IDLE; busy=0.
  - Latency: q and q_vld are valid in the cycle after the final sample.
- sync in CAPT:
  - Partial frame discarded, err set (short frame).
  - Buffer cleared, cnt=0; stay in CAPT.
  - A vld in the same cycle counts toward the new frame.
- Timeout:
  - In CAPT with vld=0, tmo increments.
  - When tmo reaches TIMEOUT-1 without a sample: → IDLE, err set, q unchanged, no q_vld.
- Precedence within one cycle: rst > sync > frame-complete > timeout.
  - If sync coincides with the final sample, the sync wins and no frame is published.
- err:
  - Cleared by err_clr=1.
  - If set and clear occur in the same cycle, set wins.
- q holds its value between completed frames. q_vld never pulses for an aborted frame.
- Reset mid-frame drops all partial state; q returns to 0.
- FRAME_SAMPLES=1: sync together with vld completes the frame in one sample.

Optional Feature:
- Macro: DOT_CAPTURE_ERRCNT_EN.
- Defined:
  - Adds output err_cnt (8 bits), reset to 0.
  - Increments once per error event: malformed sample, short frame, or timeout. If two events occur in one cycle, it still increments by 1.
  - Saturates at 255; cleared by err_clr, with increment winning over clear in the same cycle.
- Undefined: port absent; err behaviour unchanged.

Test Plan:
- Clean frame:
  - Stimulus: rst, then sync; 64 vld samples with d={8'h01<<(i/8), 8'h01<<(i%8)} for i=0..63, checkerboard subset (i with (i/8+i%8) odd made blank d=16'h0000).
  - Expect: one q_vld pulse the cycle after sample 63; q=64'hAA55AA55AA55AA55; err=0.
- Malformed sample:
  - Stimulus: frame with sample 5 = 16'h0303.
  - Expect: err=1 from the next cycle; frame still completes after 64 samples with bit 5 clear.
  - With the feature defined: err_cnt=1.
- Short frame:
  - Stimulus: sync, 10 samples lighting bit 0, sync again, then 64 blank samples.
  - Expect: err=1; q_vld after the 64th new sample; q=0.
- Timeout:
  - Stimulus: TIMEOUT=16, sync, 3 samples, then vld held low.
  - Expect: busy falls after 15 idle cycles; err=1; no q_vld; q keeps the previous frame.
- Collisions:
  - Stimulus: err_clr asserted together with a malformed sample → expect err=1.
  - Stimulus: sync together with sample 63 of a frame → expect no q_vld, busy=1, cnt restarts at 1.
- Reset mid-frame:
  - Stimulus: rst=1 at sample 30 after a prior completed frame.
  - Expect: q=0, busy=0, err=0; the next sync captures a fresh frame correctly.
